ethernet_encapsulation: RTL and testbench

Transmit-side framer that turns a length-tagged payload byte stream from the TX async FIFO into a complete GMII Ethernet frame. Each frame is preamble, SFD, destination MAC, source MAC, length field, payload, optional zero padding, and CRC-32 FCS, followed by an inter-frame gap. The block sits between the TX buffer and the PHY/loopback GMII path. Its output feeds `ethernet_decapsulation` directly in loopback benches.

---
 rtl/ethernet_encapsulation.sv | 224 ++++++++++++++++++++++
 tb/tb_ethernet_encapsulation.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_encapsulation.sv
// GMII transmit framer: preamble, SFD, DA, SA, length, payload, optional pad, FCS, then IFG.
// Zero padding of short payloads is compiled in when ETH_ENCAP_PAD_EN is defined.
module ethernet_encapsulation #(
  parameter logic [47:0] destination_mac_addr = 48'h023528fbdd66,
  parameter logic [47:0] source_mac_addr      = 48'h072227acdb65,
  parameter int unsigned IFG_BYTES            = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pct_qued,
  input  logic [10:0] pct_len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  gmii_tx_d,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        pct_txed,
  output logic        len_err,
  output logic        underrun
);

  localparam logic [10:0] MaxLen  = 11'd1500;
  localparam logic [10:0] IfgLast = 11'(IFG_BYTES - 1);
`ifdef ETH_ENCAP_PAD_EN
  localparam logic [10:0] MinPay  = 11'd46;
`endif

  typedef enum logic [3:0] {
    StIdle, StPre, StSfd, StDa, StSa, StLen, StPay, StPad, StFcs, StIfg
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;

  logic [7:0]  byte_nxt;
  logic        en_nxt, er_nxt, txed_nxt, lerr_nxt, unr_nxt, crc_upd;
  logic [47:0] da_sh, sa_sh;
  logic [31:0] fcs_sh;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign da_sh   = destination_mac_addr << {cnt_q[2:0], 3'b000};
  assign sa_sh   = source_mac_addr << {cnt_q[2:0], 3'b000};
  assign fcs_sh  = ~crc_q >> {cnt_q[1:0], 3'b000};
  assign s_ready = (state_q == StPay);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    crc_d    = crc_q;
    byte_nxt = 8'h00;
    en_nxt   = 1'b0;
    er_nxt   = 1'b0;
    txed_nxt = 1'b0;
    lerr_nxt = 1'b0;
    unr_nxt  = 1'b0;
    crc_upd  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        crc_d = 32'hFFFFFFFF;
        if (pct_qued) begin
          if (pct_len != 11'd0 && pct_len <= MaxLen) begin
            len_d   = pct_len;
            state_d = StPre;
          end else begin
            lerr_nxt = 1'b1;
          end
        end
      end
      StPre: begin
        byte_nxt = 8'h55;
        en_nxt   = 1'b1;
        if (cnt_q == 11'd6) begin
          cnt_d   = '0;
          state_d = StSfd;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StSfd: begin
        byte_nxt = 8'hD5;
        en_nxt   = 1'b1;
        cnt_d    = '0;
        state_d  = StDa;
      end
      StDa: begin
        byte_nxt = da_sh[47:40];
        en_nxt   = 1'b1;
        crc_upd  = 1'b1;
        if (cnt_q == 11'd5) begin
          cnt_d   = '0;
          state_d = StSa;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StSa: begin
        byte_nxt = sa_sh[47:40];
        en_nxt   = 1'b1;
        crc_upd  = 1'b1;
        if (cnt_q == 11'd5) begin
          cnt_d   = '0;
          state_d = StLen;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StLen: begin
        byte_nxt = (cnt_q == 11'd0) ? {5'b0, len_q[10:8]} : len_q[7:0];
        en_nxt   = 1'b1;
        crc_upd  = 1'b1;
        if (cnt_q == 11'd1) begin
          cnt_d   = '0;
          state_d = StPay;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StPay: begin
        // A missing byte still occupies its slot: send 0x00 flagged as an error.
        byte_nxt = s_valid ? s_data : 8'h00;
        er_nxt   = ~s_valid;
        unr_nxt  = ~s_valid;
        en_nxt   = 1'b1;
        crc_upd  = 1'b1;
        if (cnt_q == len_q - 11'd1) begin
          cnt_d   = '0;
          state_d = StFcs;
`ifdef ETH_ENCAP_PAD_EN
          if (len_q < MinPay) begin
            cnt_d   = cnt_q + 11'd1;
            state_d = StPad;
          end
`endif
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`ifdef ETH_ENCAP_PAD_EN
      StPad: begin
        // Counter carries on from the payload count, so the pad ends at byte 45.
        byte_nxt = 8'h00;
        en_nxt   = 1'b1;
        crc_upd  = 1'b1;
        if (cnt_q == MinPay - 11'd1) begin
          cnt_d   = '0;
          state_d = StFcs;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`endif
      StFcs: begin
        byte_nxt = fcs_sh[7:0];
        en_nxt   = 1'b1;
        if (cnt_q == 11'd3) begin
          txed_nxt = 1'b1;
          cnt_d    = '0;
          state_d  = (IFG_BYTES == 0) ? StIdle : StIfg;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StIfg: begin
        if (cnt_q == IfgLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    if (crc_upd) begin
      crc_d = crc_byte(crc_q, byte_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      crc_q      <= 32'hFFFFFFFF;
      gmii_tx_d  <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      busy       <= 1'b0;
      pct_txed   <= 1'b0;
      len_err    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      gmii_tx_d  <= byte_nxt;
      gmii_tx_en <= en_nxt;
      gmii_tx_er <= er_nxt;
      busy       <= (state_d != StIdle);
      pct_txed   <= txed_nxt;
      len_err    <= lerr_nxt;
      underrun   <= unr_nxt;
    end
  end

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// Randomized bench for ethernet_encapsulation; expected frames are built from the frame layout
// and a plain CRC-32 model. Honours ETH_ENCAP_PAD_EN the same way as the design.
module tb_ethernet_encapsulation;

  localparam logic [47:0] DaAddr = 48'h023528fbdd66;
  localparam logic [47:0] SaAddr = 48'h072227acdb65;
  localparam int          Ifg    = 12;
`ifdef ETH_ENCAP_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pct_qued = 1'b0;
  logic [10:0] pct_len = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  gmii_tx_d;
  logic        gmii_tx_en, gmii_tx_er, busy, pct_txed, len_err, underrun;

  ethernet_encapsulation #(
    .destination_mac_addr(DaAddr),
    .source_mac_addr     (SaAddr),
    .IFG_BYTES           (Ifg)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pct_qued  (pct_qued),
    .pct_len   (pct_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .gmii_tx_d (gmii_tx_d),
    .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er),
    .busy      (busy),
    .pct_txed  (pct_txed),
    .len_err   (len_err),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload source: one entry presented per s_ready cycle.
  logic [7:0] feed_d[$];
  bit         feed_drop[$];

  always @(negedge clk) begin
    if (s_ready && feed_d.size() > 0) begin
      s_data  = feed_d.pop_front();
      s_valid = !feed_drop.pop_front();
    end else begin
      s_data  = 8'($urandom);
      s_valid = 1'b0;
    end
  end

  // Frame monitor, sampled 1 time unit after each rising edge.
  logic [7:0] cur_d[$], frm_d[$];
  bit         cur_er[$], frm_er[$];
  int cur_txed_pos, cur_txed_cnt, cur_unr;
  int frm_txed_pos, frm_txed_cnt, frm_unr, frm_gap;
  int started = 0, done = 0, low_run = 0, lerr_cnt = 0, sready_cnt = 0;
  bit in_frame = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_frame = 1'b0;
      low_run  = 0;
      cur_d.delete();
      cur_er.delete();
    end else begin
      if (len_err) lerr_cnt++;
      if (s_ready) sready_cnt++;
      if (gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          started++;
          frm_gap = low_run;
          cur_d.delete();
          cur_er.delete();
          cur_txed_cnt = 0;
          cur_txed_pos = -1;
          cur_unr      = 0;
        end
        cur_d.push_back(gmii_tx_d);
        cur_er.push_back(gmii_tx_er);
        if (pct_txed) begin
          cur_txed_cnt++;
          cur_txed_pos = cur_d.size() - 1;
        end
        if (underrun) cur_unr++;
      end else begin
        if (in_frame) begin
          in_frame     = 1'b0;
          frm_d        = cur_d;
          frm_er       = cur_er;
          frm_txed_pos = cur_txed_pos;
          frm_txed_cnt = cur_txed_cnt;
          frm_unr      = cur_unr;
          low_run      = 0;
          done++;
        end
        low_run++;
      end
    end
  end

  // Reference model.
  logic [7:0] exp_d[$];
  bit         exp_er[$];

  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  task automatic build_exp(input int len, input int drop, input logic [7:0] p[$]);
    logic [47:0] da = DaAddr;
    logic [47:0] sa = SaAddr;
    logic [15:0] l16 = 16'(len);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    int          pay_n;
    body.delete();
    for (int i = 0; i < 6; i++) body.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(sa[47-8*i -: 8]);
    body.push_back(l16[15:8]);
    body.push_back(l16[7:0]);
    for (int i = 0; i < len; i++) body.push_back((i == drop) ? 8'h00 : p[i]);
    pay_n = (PadEn && len < 46) ? 46 : len;
    for (int i = len; i < pay_n; i++) body.push_back(8'h00);
    fcs = ref_fcs(body);
    exp_d.delete();
    exp_er.delete();
    for (int i = 0; i < 7; i++) exp_d.push_back(8'h55);
    exp_d.push_back(8'hD5);
    foreach (body[i]) exp_d.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_d.push_back(fcs[8*i +: 8]);
    foreach (exp_d[i]) exp_er.push_back(drop >= 0 && i == 22 + drop);
  endtask

  task automatic check_frame(input string tag, input int len, input int drop,
                             input logic [7:0] p[$]);
    int n;
    build_exp(len, drop, p);
    check_val({tag, " tx_en cycles"}, 64'(frm_d.size()), 64'(exp_d.size()));
    n = (frm_d.size() < exp_d.size()) ? frm_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s er,byte %0d", tag, i), {55'h0, frm_er[i], frm_d[i]},
                {55'h0, exp_er[i], exp_d[i]});
    end
    check_val({tag, " pct_txed count"}, 64'(frm_txed_cnt), 64'd1);
    check_val({tag, " pct_txed position"}, 64'(frm_txed_pos), 64'(exp_d.size() - 1));
    check_val({tag, " underrun count"}, 64'(frm_unr), (drop >= 0) ? 64'd1 : 64'd0);
  endtask

  task automatic wait_done(input int target, input string tag);
    int g = 0;
    while (done < target && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check_val({tag, " frame completed in budget"}, 64'(done >= target), 64'd1);
  endtask

  task automatic request(input int len);
    int g = 0;
    while (busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    pct_qued = 1'b1;
    pct_len  = 11'(len);
    @(negedge clk);
    pct_qued = 1'b0;
  endtask

  task automatic load_payload(input int len, input int drop, input bit ramp,
                              output logic [7:0] p[$]);
    p.delete();
    for (int i = 0; i < len; i++) begin
      p.push_back(ramp ? 8'(i) : 8'($urandom));
      feed_d.push_back(p[i]);
      feed_drop.push_back(i == drop);
    end
  endtask

  task automatic run_frame(input string tag, input int len, input int drop, input bit ramp);
    logic [7:0] p[$];
    int d0 = done;
    load_payload(len, drop, ramp, p);
    request(len);
    wait_done(d0 + 1, tag);
    check_frame(tag, len, drop, p);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, " gmii_tx_d"}, 64'(gmii_tx_d), 64'h0);
    check_val({tag, " gmii_tx_en"}, 64'(gmii_tx_en), 64'h0);
    check_val({tag, " gmii_tx_er"}, 64'(gmii_tx_er), 64'h0);
    check_val({tag, " s_ready"}, 64'(s_ready), 64'h0);
    check_val({tag, " busy"}, 64'(busy), 64'h0);
    check_val({tag, " pct_txed"}, 64'(pct_txed), 64'h0);
    check_val({tag, " len_err"}, 64'(len_err), 64'h0);
    check_val({tag, " underrun"}, 64'(underrun), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] p1[$], p2[$];
    int l0, r0, s0, d0, g;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame("len46 ramp", 46, -1, 1'b1);
    run_frame("len1", 1, -1, 1'b0);

    // Rejected requests: one len_err each, nothing consumed or sent.
    l0 = lerr_cnt;
    r0 = sready_cnt;
    s0 = started;
    request(0);
    repeat (3) @(negedge clk);
    check_val("len0 len_err pulses", 64'(lerr_cnt - l0), 64'd1);
    request(1501);
    repeat (20) @(negedge clk);
    check_val("len1501 len_err pulses", 64'(lerr_cnt - l0), 64'd2);
    check_val("rejected s_ready cycles", 64'(sready_cnt - r0), 64'd0);
    check_val("rejected frames started", 64'(started - s0), 64'd0);

    run_frame("underrun len100", 100, 50, 1'b0);
    run_frame("len45", 45, -1, 1'b0);
    run_frame("len47", 47, -1, 1'b0);
    run_frame("len1500", 1500, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame($sformatf("rand%0d", i), int'($urandom_range(1, 200)), -1, 1'b0);
    end

    // Back-to-back: request held high so the second frame starts at the first IDLE cycle.
    while (busy) @(negedge clk);
    d0 = done;
    s0 = started;
    load_payload(60, -1, 1'b0, p1);
    load_payload(60, -1, 1'b0, p2);
    pct_qued = 1'b1;
    pct_len  = 11'd60;
    wait_done(d0 + 1, "b2b first");
    check_frame("b2b first", 60, -1, p1);
    g = 0;
    while (started < s0 + 2 && g < 200) begin
      @(negedge clk);
      g++;
    end
    pct_qued = 1'b0;
    wait_done(d0 + 2, "b2b second");
    check_frame("b2b second", 60, -1, p2);
    check_val("b2b low cycles between frames", 64'(frm_gap), 64'(Ifg + 1));

    // Reset during payload byte 20 of a 200-byte frame.
    while (busy) @(negedge clk);
    load_payload(200, -1, 1'b0, p1);
    request(200);
    g = 0;
    while (feed_d.size() > 180 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check_val("reset point reached", 64'(feed_d.size() <= 180), 64'd1);
    d0  = done;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("mid-frame reset");
    @(negedge clk);
    rst = 1'b0;
    feed_d.delete();
    feed_drop.delete();
    @(negedge clk);
    check_val("aborted frame not completed", 64'(done - d0), 64'd0);
    run_frame("after reset len46", 46, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
